// File: rtl/placement_search.sv
// Placement search: scans every (rotation, column) candidate for the latched block and height map,
// one per cycle, and reports the legal placement with the lowest resulting stack top.
module placement_search #(
    parameter int BOARD_W  = 10,
    parameter int HEIGHT_W = 5,
    parameter int MAX_H    = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_to_client,
    input  logic [3:0]                   cur_block,
    input  logic [BOARD_W*HEIGHT_W-1:0]  col_heights,
    output logic                         resp_from_client,
    output logic [3:0]                   opt_col,
    output logic [1:0]                   opt_rotation,
    output logic                         resp_none,
    output logic                         busy
);

    localparam int TW = HEIGHT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                        state;
    logic [BOARD_W*HEIGHT_W-1:0]   heights_q;
    logic [3:0]                    blk_q;
    logic [1:0]                    rot_q;
    logic [3:0]                    col_q;

    logic                          best_vld;
    logic [TW-1:0]                 best_top;
    logic [3:0]                    best_col;
    logic [1:0]                    best_rot;

    logic [2:0]                    fp_w;
    logic [2:0]                    fp_h;
    logic                          type_ok;
    logic [HEIGHT_W-1:0]           base;
    logic [HEIGHT_W-1:0]           hj;
    logic [TW-1:0]                 top;
    logic                          fits;
    logic                          legal;
    logic                          last;

    logic                          nb_vld;
    logic [TW-1:0]                 nb_top;
    logic [3:0]                    nb_col;
    logic [1:0]                    nb_rot;

    // Footprint of the latched block; odd rotations are the upright orientation.
    always_comb begin
        fp_w    = 3'd1;
        fp_h    = 3'd1;
        type_ok = 1'b1;
        case (blk_q)
            4'd0: begin
                fp_w = rot_q[0] ? 3'd1 : 3'd4;
                fp_h = rot_q[0] ? 3'd4 : 3'd1;
            end
            4'd1: begin
                fp_w = 3'd2;
                fp_h = 3'd2;
            end
            4'd2: begin
                fp_w = rot_q[0] ? 3'd1 : 3'd3;
                fp_h = rot_q[0] ? 3'd3 : 3'd1;
            end
            4'd3: begin
                fp_w = rot_q[0] ? 3'd1 : 3'd2;
                fp_h = rot_q[0] ? 3'd2 : 3'd1;
            end
            default: type_ok = 1'b0;
        endcase
    end

    always_comb begin
        base = '0;
        hj   = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < int'(fp_w) && (int'(col_q) + j) < BOARD_W) begin
                hj = heights_q[(int'(col_q) + j)*HEIGHT_W +: HEIGHT_W];
                if (hj > base)
                    base = hj;
            end
        end
        // One extra bit so an all-ones height plus block height cannot wrap.
        top   = {1'b0, base} + TW'(fp_h);
        fits  = (5'(col_q) + 5'(fp_w)) <= 5'(BOARD_W);
        legal = type_ok && fits && (top <= TW'(MAX_H));
        last  = (rot_q == 2'd3) && (col_q == 4'(BOARD_W - 1));
    end

    // Strict less-than keeps the earliest candidate on ties (lowest rotation, then column).
    always_comb begin
        nb_vld = best_vld;
        nb_top = best_top;
        nb_col = best_col;
        nb_rot = best_rot;
        if (legal && (!best_vld || top < best_top)) begin
            nb_vld = 1'b1;
            nb_top = top;
            nb_col = col_q;
            nb_rot = rot_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            heights_q        <= '0;
            blk_q            <= '0;
            rot_q            <= '0;
            col_q            <= '0;
            best_vld         <= 1'b0;
            best_top         <= '0;
            best_col         <= '0;
            best_rot         <= '0;
            resp_from_client <= 1'b0;
            opt_col          <= '0;
            opt_rotation     <= '0;
            resp_none        <= 1'b0;
            busy             <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    resp_from_client <= 1'b0;
                    if (req_to_client) begin
                        heights_q <= col_heights;
                        blk_q     <= cur_block;
                        best_vld  <= 1'b0;
                        rot_q     <= '0;
                        col_q     <= '0;
                        busy      <= 1'b1;
                        state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    best_vld <= nb_vld;
                    best_top <= nb_top;
                    best_col <= nb_col;
                    best_rot <= nb_rot;
                    if (last) begin
                        opt_col          <= nb_vld ? nb_col : 4'd0;
                        opt_rotation     <= nb_vld ? nb_rot : 2'd0;
                        resp_none        <= !nb_vld;
                        resp_from_client <= 1'b1;
                        state            <= S_RESP;
                    end else if (col_q == 4'(BOARD_W - 1)) begin
                        col_q <= '0;
                        rot_q <= rot_q + 2'd1;
                    end else begin
                        col_q <= col_q + 4'd1;
                    end
                end
                S_RESP: begin
                    resp_from_client <= 1'b0;
                    busy             <= 1'b0;
                    state            <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_placement_search.sv
// Bench for placement_search: directed cases plus randomized searches against a reference model.
module tb_placement_search;

    localparam int W  = 10;
    localparam int HW = 5;
    localparam int MH = 20;

    logic              clk;
    logic              rst;
    logic              req_to_client;
    logic [3:0]        cur_block;
    logic [W*HW-1:0]   col_heights;
    logic              resp_from_client;
    logic [3:0]        opt_col;
    logic [1:0]        opt_rotation;
    logic              resp_none;
    logic              busy;

    int checks;
    int failures;
    int hts[W];

    int r_lat, r_busy, r_none, r_col, r_rot, r_after;

    placement_search #(.BOARD_W(W), .HEIGHT_W(HW), .MAX_H(MH)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_to_client    (req_to_client),
        .cur_block        (cur_block),
        .col_heights      (col_heights),
        .resp_from_client (resp_from_client),
        .opt_col          (opt_col),
        .opt_rotation     (opt_rotation),
        .resp_none        (resp_none),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: enumerate placements in scan order, keep the first with the lowest top.
    function automatic void model(input int blk, output int none, output int col, output int rot);
        int best, w, h, base, top;
        bit found;
        found = 0; best = 0; col = 0; rot = 0;
        if (blk <= 3) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < W; c++) begin
                    case (blk)
                        0: begin w = (r % 2) ? 1 : 4; h = (r % 2) ? 4 : 1; end
                        1: begin w = 2; h = 2; end
                        2: begin w = (r % 2) ? 1 : 3; h = (r % 2) ? 3 : 1; end
                        default: begin w = (r % 2) ? 1 : 2; h = (r % 2) ? 2 : 1; end
                    endcase
                    if (c + w <= W) begin
                        base = 0;
                        for (int j = 0; j < w; j++)
                            if (hts[c+j] > base) base = hts[c+j];
                        top = base + h;
                        if (top <= MH && (!found || top < best)) begin
                            found = 1; best = top; col = c; rot = r;
                        end
                    end
                end
            end
        end
        none = found ? 0 : 1;
    endfunction

    task automatic drive_heights();
        for (int c = 0; c < W; c++)
            col_heights[c*HW +: HW] = hts[c][HW-1:0];
    endtask

    // Issues one request; optionally zeroes the heights after edge chg_at to prove they were latched.
    task automatic run_search(input int blk, input int chg_at);
        bit got;
        @(negedge clk);
        cur_block = blk[3:0];
        drive_heights();
        req_to_client = 1'b1;
        @(posedge clk);
        #1;
        r_busy = busy ? 1 : 0;
        @(negedge clk);
        req_to_client = 1'b0;
        r_lat = 0;
        got = 0;
        while (!got && r_lat < 200) begin
            @(posedge clk);
            r_lat++;
            #1;
            if (busy) r_busy++;
            if (resp_from_client) begin
                got = 1;
                r_none = resp_none ? 1 : 0;
                r_col = int'(opt_col);
                r_rot = int'(opt_rotation);
            end
            if (r_lat == chg_at) begin
                @(negedge clk);
                col_heights = '0;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL resp_timeout got_edges=%0d required=40", r_lat);
            r_none = -1; r_col = -1; r_rot = -1;
        end
        @(posedge clk);
        #1;
        if (busy) r_busy++;
        r_after = resp_from_client ? 1 : 0;
    endtask

    task automatic check_result(input string name, input int e_none, input int e_col, input int e_rot);
        checks++;
        if (r_none !== e_none || r_col !== e_col || r_rot !== e_rot) begin
            failures++;
            $display("FAIL %s got none=%0d col=%0d rot=%0d required none=%0d col=%0d rot=%0d",
                     name, r_none, r_col, r_rot, e_none, e_col, e_rot);
        end
        checks++;
        if (r_lat !== 40) begin
            failures++;
            $display("FAIL %s_latency got=%0d required=40", name, r_lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_to_client = 1'b0;
        cur_block = '0;
        col_heights = '0;
        #3;
        checks++;
        if ({resp_from_client, opt_col, opt_rotation, resp_none, busy} !== 9'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b required=0",
                     {resp_from_client, opt_col, opt_rotation, resp_none, busy});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int c = 0; c < W; c++) hts[c] = 0;
        run_search(1, -1);
        check_result("flat_O", 0, 0, 0);
        checks++;
        if (r_busy !== 41) begin
            failures++;
            $display("FAIL busy_cycles got=%0d required=41", r_busy);
        end
        checks++;
        if (r_after !== 0) begin
            failures++;
            $display("FAIL resp_pulse_width got_high_next=%0d required=0", r_after);
        end
    endtask

    task automatic test_directed();
        hts = '{3, 3, 0, 0, 0, 0, 0, 0, 5, 5};
        run_search(0, -1);
        check_result("i4_gap", 0, 2, 0);
        for (int c = 0; c < W; c++) hts[c] = 19;
        run_search(1, -1);
        check_result("o_too_high", 1, 0, 0);
        run_search(0, -1);
        check_result("i4_at_max", 0, 0, 0);
        for (int c = 0; c < W; c++) hts[c] = 0;
        run_search(7, -1);
        check_result("illegal_type", 1, 0, 0);
        for (int c = 0; c < W; c++) hts[c] = 31;
        run_search(3, -1);
        check_result("all_ones_heights", 1, 0, 0);
        hts = '{9, 9, 9, 9, 9, 9, 9, 9, 9, 0};
        run_search(3, -1);
        check_result("domino_well", 0, 9, 1);
    endtask

    task automatic test_scan_change();
        hts = '{9, 9, 9, 9, 9, 9, 9, 9, 9, 0};
        run_search(3, 5);
        check_result("heights_change_midscan", 0, 9, 1);
    endtask

    task automatic test_reset_midscan();
        int n, first, second, seen_pulse;
        for (int c = 0; c < W; c++) hts[c] = 0;
        @(negedge clk);
        cur_block = 4'd1;
        drive_heights();
        req_to_client = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_to_client = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({resp_from_client, opt_col, opt_rotation, resp_none, busy} !== 9'd0) begin
            failures++;
            $display("FAIL midscan_reset_outputs got=%b required=0",
                     {resp_from_client, opt_col, opt_rotation, resp_none, busy});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen_pulse = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (resp_from_client || busy) seen_pulse = 1;
        end
        checks++;
        if (seen_pulse !== 0) begin
            failures++;
            $display("FAIL idle_after_reset got_activity=%0d required=0", seen_pulse);
        end
        @(negedge clk);
        req_to_client = 1'b1;
        @(posedge clk);
        n = 0; first = -1; second = -1;
        while (second < 0 && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (resp_from_client) begin
                if (first < 0) first = n;
                else second = n;
            end
        end
        @(negedge clk);
        req_to_client = 1'b0;
        checks++;
        if (first !== 40 || second !== 82) begin
            failures++;
            $display("FAIL back_to_back got=%0d,%0d required=40,82", first, second);
        end
        repeat (50) @(posedge clk);
    endtask

    task automatic test_random();
        int blk, lim, e_none, e_col, e_rot;
        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 2))
                0: lim = 3;
                1: lim = 20;
                default: lim = 31;
            endcase
            for (int c = 0; c < W; c++) hts[c] = $urandom_range(0, lim);
            blk = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
            model(blk, e_none, e_col, e_rot);
            run_search(blk, -1);
            check_result($sformatf("random_%0d_blk%0d", t, blk), e_none, e_col, e_rot);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_directed();
        test_scan_change();
        test_random();
        test_reset_midscan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/placement_search.md
# placement_search

Parametrised placement search engine for the falling-block player. On a request it latches the current column height map and block type. It then scans every (rotation, column) candidate, one per cycle, and returns the legal placement with the lowest resulting stack top as `opt_col` / `opt_rotation` with a one-cycle response pulse. It sits between the game controller (request side) and the move executor (consumer of the response). It generalises the fixed 2-column / 4-column anchor lookup to any board width and a four-shape block set, and adds real height-aware scoring.

## Interface
- `BOARD_W`, 10, number of board columns (4..15)
- `HEIGHT_W`, 5, bits per column height
- `MAX_H`, 20, maximum legal stack height; placements whose top exceeds this are illegal
- `clk`  input  1  clock; all state changes on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `req_to_client`  input  1  search request (level); sampled only in IDLE
- `cur_block`  input  4  block type; latched with the request
- `col_heights`  input  BOARD_W*HEIGHT_W  column c height at `[c*HEIGHT_W +: HEIGHT_W]`; latched with the request
- `resp_from_client`  output  1  single-cycle pulse: result valid
- `opt_col`  output  4  leftmost column of the chosen footprint
- `opt_rotation`  output  2  chosen rotation, 0..3
- `resp_none`  output  1  valid with the pulse: no legal placement, or illegal block type
- `busy`  output  1  high in SCAN and RESP

## Operation
- Block footprints (width w, height h, flat bottom):
  - type 0, I4: rot 0/2 are w4 h1; rot 1/3 are w1 h4.
  - type 1, O: all rotations w2 h2.
  - type 2, I3: rot 0/2 are w3 h1; rot 1/3 are w1 h3.
  - type 3, domino: rot 0/2 are w2 h1; rot 1/3 are w1 h2.
  - types 4..15 are illegal.
- Candidate index k runs 0..4*BOARD_W-1, with rot = k / BOARD_W and col = k % BOARD_W. Rotation is the outer loop and column the inner loop.
- For each candidate:
  - base = max of latched heights over columns col..col+w-1.
  - top = base + h, computed at HEIGHT_W+1 bits so it never wraps.
- A candidate is legal iff col + w <= BOARD_W and top <= MAX_H.
- Best-candidate selection:
  - A candidate replaces the current best only if it is legal and its top is strictly less than the best top.
  - The first legal candidate always becomes best.
  - Ties therefore resolve to lowest rotation first, then lowest column.
- If no candidate is legal, or the block type is illegal:
  - `resp_none` = 1, `opt_col` = 0, `opt_rotation` = 0.
  - An illegal type still takes the full scan time.
- FSM:
  - IDLE: on `req_to_client` = 1, latch `cur_block` and `col_heights`, clear the best-valid flag, set k = 0, go to SCAN.
  - SCAN: evaluate candidate k and update best. If k = 4*BOARD_W-1 go to RESP, else k++.
  - RESP: assert `resp_from_client` for one cycle and drive the result, then go to IDLE unconditionally.
- `opt_col`, `opt_rotation` and `resp_none` are registered. They update only on entry to RESP and hold until the next RESP.
- `req_to_client` is ignored in SCAN and RESP; no queuing.
- `col_heights` and `cur_block` may change freely after the latching edge.

## Timing
- Reset values, asynchronous and immediate:
  - State is IDLE.
  - `resp_from_client`, `opt_col`, `opt_rotation`, `resp_none` and `busy` are all 0.
- Edge E0: IDLE samples req = 1.
- Candidates k = 0..4W-1 are consumed at edges E1..E(4W).
- `resp_from_client` is high for exactly the cycle between E(4W) and E(4W+1). This gives a latency of 4*BOARD_W edges: 40 for W = 10.
- `busy` rises after E0 and falls after E(4W+1).
- With req held high, back-to-back responses are 4*BOARD_W+2 edges apart: 42 for W = 10.
- Reset asserted mid-scan: the search is abandoned, no response is produced, and outputs return to 0. After release, the block waits in IDLE for a new request.
- Heights at MAX_H or all-max, and 2^HEIGHT_W-1 inputs, must not overflow `top`.

## Test plan
- Reset, then heights all 0, block 1 (O), req pulse at E0 -> resp at E40, `opt_col` = 0, `opt_rotation` = 0, `resp_none` = 0, `busy` high for 41 cycles.
- Heights [3,3,0,0,0,0,0,0,5,5] (col 0..9), block 0 (I4) -> `opt_col` = 2, `opt_rotation` = 0 (top 1 beats vertical top 4).
- Heights all 19, block 1 -> `resp_none` = 1, col 0, rot 0. Same heights with block 0 -> rot 0, col 0, `resp_none` = 0 (top 20 = MAX_H is legal).
- Block 7, heights all 0 -> resp at E40 with `resp_none` = 1, col 0, rot 0.
- Heights [9,9,9,9,9,9,9,9,9,0], block 3 (domino) -> `opt_col` = 9, `opt_rotation` = 1. Then change `col_heights` at E5 during the scan -> result unchanged.
- Request, then assert `rst` between E10 and E11 -> outputs 0, no pulse. After release, req held high -> responses at 40 and 82 edges after the first sampling edge.
